udp_reg_ring_master: RTL and testbench

Initiator for the user-datapath register ring: accepts single register read/write requests from a host-side core and launches each one as a frame on the ring. Every datapath block's register slave passes or acknowledges the frame. The block then collects the frame when it returns, or times it out, and reports data and status back to the core. It sits at the head of the ring and closes it, one hop before the first user-datapath block's `reg_*_in` ports.

---
 rtl/udp_reg_ring_master_if.sv | 86 ++++++++
 rtl/udp_reg_ring_master.sv | 162 ++++++++++++++++
 tb/tb_udp_reg_ring_master.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_reg_ring_master_if.sv
// Register ring master bus bundle: the host core request/response signals,
// the frame launched onto the ring, the frame returning from the last slave,
// and the discard counter. The master modport is the ring master's own view;
// the slave modport is the view of the core and ring around it.
interface udp_reg_ring_master_if #(
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int REG_ADDR_WIDTH    = 23,
    parameter int DATA_WIDTH        = 32
);
    // host core side
    logic                         core_reg_req;
    logic                         core_reg_rd_wr_L;
    logic [REG_ADDR_WIDTH-1:0]    core_reg_addr;
    logic [DATA_WIDTH-1:0]        core_reg_wr_data;
    logic                         core_reg_ack;
    logic [DATA_WIDTH-1:0]        core_reg_rd_data;
    logic [1:0]                   core_reg_status;
    logic                         core_reg_busy;

    // frame launched toward the first slave
    logic                         reg_req_out;
    logic                         reg_ack_out;
    logic                         reg_rd_wr_L_out;
    logic [REG_ADDR_WIDTH-1:0]    reg_addr_out;
    logic [DATA_WIDTH-1:0]        reg_data_out;
    logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out;

    // frame returning from the last slave
    logic                         reg_req_in;
    logic                         reg_ack_in;
    logic                         reg_rd_wr_L_in;
    logic [REG_ADDR_WIDTH-1:0]    reg_addr_in;
    logic [DATA_WIDTH-1:0]        reg_data_in;
    logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in;

    // count of returning frames that were thrown away
    logic [7:0]                   drop_count;

    modport master (
        input  core_reg_req,
        input  core_reg_rd_wr_L,
        input  core_reg_addr,
        input  core_reg_wr_data,
        output core_reg_ack,
        output core_reg_rd_data,
        output core_reg_status,
        output core_reg_busy,
        output reg_req_out,
        output reg_ack_out,
        output reg_rd_wr_L_out,
        output reg_addr_out,
        output reg_data_out,
        output reg_src_out,
        input  reg_req_in,
        input  reg_ack_in,
        input  reg_rd_wr_L_in,
        input  reg_addr_in,
        input  reg_data_in,
        input  reg_src_in,
        output drop_count
    );

    modport slave (
        output core_reg_req,
        output core_reg_rd_wr_L,
        output core_reg_addr,
        output core_reg_wr_data,
        input  core_reg_ack,
        input  core_reg_rd_data,
        input  core_reg_status,
        input  core_reg_busy,
        input  reg_req_out,
        input  reg_ack_out,
        input  reg_rd_wr_L_out,
        input  reg_addr_out,
        input  reg_data_out,
        input  reg_src_out,
        output reg_req_in,
        output reg_ack_in,
        output reg_rd_wr_L_in,
        output reg_addr_in,
        output reg_data_in,
        output reg_src_in,
        input  drop_count
    );
endinterface

// File: rtl/udp_reg_ring_master.sv
// Register ring master: takes one register read or write from the host core,
// launches it as a single frame on the user-datapath register ring, waits for
// it to come back (or gives up after TIMEOUT cycles) and hands data and status
// back to the core. Any returning frame that is not the one being waited for
// is dropped and counted, which also closes the ring.
module udp_reg_ring_master #(
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int SRC_ID            = 0,
    parameter int REG_ADDR_WIDTH    = 23,
    parameter int DATA_WIDTH        = 32,
    parameter int TIMEOUT           = 127
) (
    input  logic                   clk,
    input  logic                   reset_n,
    udp_reg_ring_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Completion status codes reported to the core.
    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_NOACK   = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    // Timer holds 0..TIMEOUT; the last WAIT cycle sees TIMEOUT-1.
    localparam int TIMER_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT - 1);

    localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG = UDP_REG_SRC_WIDTH'(SRC_ID);

    // Filler data returned for failed accesses, fitted to the data width.
    localparam logic [DATA_WIDTH-1:0] BAD_DATA = DATA_WIDTH'(32'hDEADBEEF);

    state_t                    state;
    state_t                    state_next;

    logic [REG_ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]     lat_wr_data;
    logic                      lat_rd_wr_L;

    logic [TIMER_WIDTH-1:0]    timer;

    logic [DATA_WIDTH-1:0]     resp_data;
    logic [1:0]                resp_status;

    logic [7:0]                drop_cnt;

    logic                      accept_req;
    logic                      ring_match;
    logic                      timed_out;
    logic                      drop_frame;
    logic                      is_issue;
    logic                      is_done;

    // The returning frame's address and direction are not needed: the source
    // tag alone identifies our frame since only one is ever in flight.
    logic                      unused_ring_in;
    assign unused_ring_in = ^{bus.reg_addr_in, bus.reg_rd_wr_L_in};

    // Event decode shared by the state machine and the datapath registers.
    assign accept_req = (state == IDLE) && bus.core_reg_req;
    assign ring_match = (state == WAIT) && bus.reg_req_in && (bus.reg_src_in == SRC_TAG);
    assign timed_out  = (state == WAIT) && !ring_match && (timer == TIMER_LAST);
    assign drop_frame = bus.reg_req_in && !ring_match;
    assign is_issue   = (state == ISSUE);
    assign is_done    = (state == DONE);

    // State register; reset returns to IDLE from anywhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: ISSUE and DONE are single cycles, WAIT ends on a match or timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (ring_match || timed_out) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the request fields so the core may change its bus after the pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_addr    <= '0;
            lat_wr_data <= '0;
            lat_rd_wr_L <= 1'b0;
        end else if (accept_req) begin
            lat_addr    <= bus.core_reg_addr;
            lat_wr_data <= bus.core_reg_wr_data;
            lat_rd_wr_L <= bus.core_reg_rd_wr_L;
        end
    end

    // Wait timer: cleared while the frame is launched, counts every WAIT cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (is_issue) begin
            timer <= '0;
        end else if (state == WAIT) begin
            timer <= timer + 1'b1;
        end
    end

    // Response capture; a match takes priority over a timeout in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_data   <= '0;
            resp_status <= STATUS_OK;
        end else if (ring_match) begin
            if (bus.reg_ack_in) begin
                resp_data   <= bus.reg_data_in;
                resp_status <= STATUS_OK;
            end else begin
                resp_data   <= BAD_DATA;
                resp_status <= STATUS_NOACK;
            end
        end else if (timed_out) begin
            resp_data   <= BAD_DATA;
            resp_status <= STATUS_TIMEOUT;
        end
    end

    // Saturating count of returning frames that are swallowed instead of forwarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= 8'd0;
        end else if (drop_frame && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Ring outputs are live only in ISSUE so the ring sees exactly one frame;
    // reads carry zero data.
    assign bus.reg_req_out     = is_issue;
    assign bus.reg_ack_out     = 1'b0;
    assign bus.reg_rd_wr_L_out = is_issue && lat_rd_wr_L;
    assign bus.reg_addr_out    = is_issue ? lat_addr : '0;
    assign bus.reg_data_out    = (is_issue && !lat_rd_wr_L) ? lat_wr_data : '0;
    assign bus.reg_src_out     = is_issue ? SRC_TAG : '0;

    // Core outputs: data and status are presented only alongside the ack pulse.
    assign bus.core_reg_ack     = is_done;
    assign bus.core_reg_rd_data = is_done ? resp_data : '0;
    assign bus.core_reg_status  = is_done ? resp_status : 2'b00;
    assign bus.core_reg_busy    = (state != IDLE);
    assign bus.drop_count       = drop_cnt;

endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Testbench for udp_reg_ring_master: a ring of register slaves is modelled as a
// small register file plus a per-transaction return delay; expected status,
// data, latency and drop counts come from that model.
module tb_udp_reg_ring_master;

    localparam int SRC_W = 2;
    localparam int AW    = 23;
    localparam int DW    = 32;
    localparam int TMO   = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int nChecks = 0;
    int nPass   = 0;
    int expDrop = 0;

    // slave register file: addresses 0..255 are mapped, everything else NOACKs
    logic [31:0] regFile [256];

    always #5 clk = ~clk;

    udp_reg_ring_master_if #(
        .UDP_REG_SRC_WIDTH(SRC_W),
        .REG_ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) bus ();

    udp_reg_ring_master #(
        .UDP_REG_SRC_WIDTH(SRC_W),
        .SRC_ID(0),
        .REG_ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.master)
    );

    // Single point of comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clearRing();
        bus.reg_req_in     = 1'b0;
        bus.reg_ack_in     = 1'b0;
        bus.reg_rd_wr_L_in = 1'b0;
        bus.reg_addr_in    = '0;
        bus.reg_data_in    = '0;
        bus.reg_src_in     = '0;
    endtask

    task automatic driveFrame(input logic [SRC_W-1:0] src, input logic ack, input logic rdwr,
                              input logic [AW-1:0] addr, input logic [31:0] data);
        bus.reg_req_in     = 1'b1;
        bus.reg_ack_in     = ack;
        bus.reg_rd_wr_L_in = rdwr;
        bus.reg_addr_in    = addr;
        bus.reg_data_in    = data;
        bus.reg_src_in     = src;
    endtask

    task automatic noteDrop();
        if (expDrop < 255) expDrop++;
    endtask

    // One core transaction. Called at a negedge with the DUT idle; returns at the
    // negedge of the cycle after the ack so a following call is back-to-back.
    // lat: ring delay; ret: whether the frame comes back at all;
    // foreignAt / busyAt: cycle (relative to the request cycle 0) of a foreign
    // frame / an ignored core request, 0 for none.
    task automatic applyStimulus(input logic rd, input logic [AW-1:0] addr, input logic [31:0] wdata,
                                 input int lat, input bit ret, input int foreignAt, input int busyAt);
        logic        respAck;
        logic [31:0] respData;
        logic [31:0] expData;
        logic [1:0]  expStatus;
        int          ackAt;
        int          extraLaunch;
        bit          seen;

        respAck  = 1'b0;
        respData = $urandom;
        if (ret) begin
            if (addr < 256) begin
                respAck = 1'b1;
                if (!rd) regFile[addr[7:0]] = wdata;
                respData  = rd ? regFile[addr[7:0]] : wdata;
                expData   = respData;
                expStatus = 2'b00;
            end else begin
                expData   = 32'hDEADBEEF;
                expStatus = 2'b01;
            end
            ackAt = lat + 2;
        end else begin
            expData   = 32'hDEADBEEF;
            expStatus = 2'b10;
            ackAt     = TMO + 2;
        end

        bus.core_reg_req      = 1'b1;
        bus.core_reg_rd_wr_L  = rd;
        bus.core_reg_addr     = addr;
        bus.core_reg_wr_data  = wdata;
        tick();
        bus.core_reg_req      = 1'b0;
        bus.core_reg_addr     = AW'($urandom);
        bus.core_reg_wr_data  = $urandom;
        bus.core_reg_rd_wr_L  = ~rd;

        checkOutput("launch_req",  32'(bus.reg_req_out), 32'd1);
        checkOutput("launch_ack",  32'(bus.reg_ack_out), 32'd0);
        checkOutput("launch_addr", 32'(bus.reg_addr_out), 32'(addr));
        checkOutput("launch_src",  32'(bus.reg_src_out), 32'd0);
        checkOutput("launch_rdwr", 32'(bus.reg_rd_wr_L_out), 32'(rd));
        checkOutput("launch_data", bus.reg_data_out, rd ? 32'd0 : wdata);
        checkOutput("busy_issue",  32'(bus.core_reg_busy), 32'd1);

        extraLaunch = 0;
        seen = 1'b0;
        for (int c = 1; c < TMO + 12 && !seen; c++) begin
            clearRing();
            if (ret && c == lat + 1) begin
                driveFrame(2'd0, respAck, rd, addr, respData);
            end else if (c == foreignAt) begin
                driveFrame(2'd2, 1'b1, rd, addr, $urandom);
                noteDrop();
            end
            if (c == busyAt) begin
                bus.core_reg_req     = 1'b1;
                bus.core_reg_addr    = AW'($urandom);
                bus.core_reg_rd_wr_L = 1'($urandom);
            end
            tick();
            bus.core_reg_req = 1'b0;
            clearRing();
            if (bus.reg_req_out) extraLaunch++;
            if (bus.core_reg_ack) begin
                seen = 1'b1;
                checkOutput("ack_latency", 32'(c + 1), 32'(ackAt));
                checkOutput("rd_data",     bus.core_reg_rd_data, expData);
                checkOutput("status",      32'(bus.core_reg_status), 32'(expStatus));
            end
        end
        if (!seen) checkOutput("ack_seen", 32'd0, 32'd1);
        checkOutput("extra_launch", 32'(extraLaunch), 32'd0);

        tick();
        checkOutput("busy_after",   32'(bus.core_reg_busy), 32'd0);
        checkOutput("ack_after",    32'(bus.core_reg_ack), 32'd0);
        checkOutput("launch_after", 32'(bus.reg_req_out), 32'd0);
        checkOutput("drop_count",   32'(bus.drop_count), 32'(expDrop));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.core_reg_req     = 1'b0;
        bus.core_reg_rd_wr_L = 1'b0;
        bus.core_reg_addr    = '0;
        bus.core_reg_wr_data = '0;
        clearRing();
        for (int i = 0; i < 256; i++) regFile[i] = $urandom;

        #1;
        checkOutput("rst_busy",  32'(bus.core_reg_busy), 32'd0);
        checkOutput("rst_ack",   32'(bus.core_reg_ack), 32'd0);
        checkOutput("rst_req",   32'(bus.reg_req_out), 32'd0);
        checkOutput("rst_drop",  32'(bus.drop_count), 32'd0);
        checkOutput("rst_data",  bus.core_reg_rd_data, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] read OK");
        regFile[16] = 32'h12345678;
        applyStimulus(1'b1, 23'h000010, 32'h0, 3, 1'b1, 0, 0);

        $display("[TB] write NOACK");
        applyStimulus(1'b0, 23'h400000, 32'hA5A5A5A5, 2, 1'b1, 0, 0);

        $display("[TB] timeout then stale frame");
        applyStimulus(1'b1, 23'h000020, 32'h0, 1, 1'b0, 0, 0);
        driveFrame(2'd0, 1'b1, 1'b1, 23'h000020, 32'h11111111);
        noteDrop();
        tick();
        clearRing();
        checkOutput("stale_ack",  32'(bus.core_reg_ack), 32'd0);
        checkOutput("stale_drop", 32'(bus.drop_count), 32'(expDrop));
        tick();
        checkOutput("stale_ack2", 32'(bus.core_reg_ack), 32'd0);

        $display("[TB] foreign src and busy request");
        applyStimulus(1'b1, 23'h000010, 32'h0, 4, 1'b1, 2, 3);

        $display("[TB] reset mid-operation");
        bus.core_reg_req     = 1'b1;
        bus.core_reg_rd_wr_L = 1'b1;
        bus.core_reg_addr    = 23'h000030;
        tick();
        bus.core_reg_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        expDrop = 0;
        #1;
        checkOutput("mid_rst_busy", 32'(bus.core_reg_busy), 32'd0);
        checkOutput("mid_rst_req",  32'(bus.reg_req_out), 32'd0);
        checkOutput("mid_rst_ack",  32'(bus.core_reg_ack), 32'd0);
        checkOutput("mid_rst_drop", 32'(bus.drop_count), 32'd0);
        tick();
        reset_n = 1'b1;
        driveFrame(2'd0, 1'b1, 1'b1, 23'h000030, regFile[48]);
        noteDrop();
        tick();
        clearRing();
        checkOutput("old_frame_drop", 32'(bus.drop_count), 32'(expDrop));
        applyStimulus(1'b0, 23'h000031, 32'hCAFEF00D, 2, 1'b1, 0, 0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            logic         rd;
            logic [AW-1:0] addr;
            int           lat;
            bit           ret;
            int           fAt;
            int           bAt;
            rd   = 1'($urandom);
            addr = ($urandom_range(3) == 0) ? AW'(256 + $urandom_range(100000)) : AW'($urandom_range(255));
            ret  = ($urandom_range(4) != 0);
            lat  = $urandom_range(6, 1);
            fAt  = 0;
            if ($urandom_range(2) == 0) fAt = ret ? $urandom_range(lat, 1) : $urandom_range(TMO + 1, 1);
            bAt  = 0;
            if ($urandom_range(2) == 0) bAt = $urandom_range(ret ? lat + 1 : TMO + 1, 1);
            applyStimulus(rd, addr, $urandom, lat, ret, fAt, bAt);
        end

        $display("[TB] drop saturation");
        for (int i = 0; i < 300; i++) begin
            driveFrame(2'd2, 1'b1, 1'b0, AW'($urandom), $urandom);
            noteDrop();
            tick();
        end
        clearRing();
        tick();
        checkOutput("drop_sat", 32'(bus.drop_count), 32'(expDrop));
        checkOutput("drop_sat_255", 32'(bus.drop_count), 32'd255);

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 23'h000010, 32'h0, 3, 1'b1, 0, 0);
        applyStimulus(1'b0, 23'h000011, 32'h87654321, 3, 1'b1, 0, 0);
        applyStimulus(1'b1, 23'h000011, 32'h0, 5, 1'b1, 0, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
